lit_merge_unit: RTL

LIT_MERGE_UNIT -- requirements
Module: lit_merge_unit

---
 rtl/lit_merge_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lit_merge_unit.sv
// lit_merge_unit: merges NUM_PARSER literal channels and one copy channel
// into a single in-order output FIFO. Copies have priority, but only for
// COPY_MAX consecutive grants while a literal is waiting. Literal channels
// are served round-robin.
module lit_merge_unit #(
  parameter int NUM_PARSER = 6,
  parameter int NUM_LOG    = 3,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int COPY_MAX   = 4,
  localparam int BV_W      = DATA_W / 8,
  localparam int FIFO_LOG  = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W*NUM_PARSER-1:0] lit_data,
  input  logic [ADDR_W*NUM_PARSER-1:0] lit_address,
  input  logic [BV_W*NUM_PARSER-1:0]   lit_byte_valid,
  input  logic [NUM_PARSER-1:0]        lit_valid,
  output logic [NUM_PARSER-1:0]        lit_ready,
  input  logic [DATA_W-1:0]            copy_data,
  input  logic [ADDR_W-1:0]            copy_address,
  input  logic [BV_W-1:0]              copy_byte_valid,
  input  logic                         copy_valid,
  output logic                         copy_ready,
  output logic [DATA_W-1:0]            data_out,
  output logic [ADDR_W-1:0]            address_out,
  output logic [BV_W-1:0]              byte_valid_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [FIFO_LOG:0]            fifo_count
);

  localparam int ENTRY_W = DATA_W + ADDR_W + BV_W;
  localparam logic [FIFO_LOG:0] DEPTH_C   = (FIFO_LOG + 1)'(FIFO_DEPTH);
  localparam logic [3:0]        STARVE_MAX = 4'(COPY_MAX);

  logic [NUM_PARSER-1:0] base_q, base_d;
  logic [3:0]            starve_q, starve_d;
  logic [FIFO_LOG-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG:0]     count_q, count_d;
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    mem_d [FIFO_DEPTH];

  logic                  space;
  logic                  lit_any;
  logic                  copy_win;
  logic                  lit_go;
  logic                  push;
  logic                  pop;
  logic [NUM_PARSER-1:0] grant_oh;
  logic [NUM_LOG-1:0]    grant_idx;
  logic [ENTRY_W-1:0]    push_entry;

  // Output FIFO head; payload forced to zero when the FIFO is empty
  always_comb begin
    valid_out  = (count_q != '0);
    fifo_count = count_q;
    pop        = valid_out & ready_in;
    if (valid_out) begin
      {data_out, address_out, byte_valid_out} = mem_q[rd_ptr_q];
    end else begin
      {data_out, address_out, byte_valid_out} = '0;
    end
  end

  // Arbitration: copy priority with starvation cap, round-robin literals
  always_comb begin
    int unsigned base_i;
    int unsigned idx;
    logic        found;
    base_i    = 0;
    idx       = 0;
    found     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_PARSER; i++) begin
      if (base_q[i]) base_i = i;
    end
    for (int unsigned k = 0; k < NUM_PARSER; k++) begin
      idx = base_i + k;
      if (idx >= NUM_PARSER) idx = idx - NUM_PARSER;
      if (!found && lit_valid[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = NUM_LOG'(idx);
      end
    end
    space    = (count_q < DEPTH_C) | pop;
    lit_any  = (lit_valid != '0);
    copy_win = rst_n & copy_valid & space & ~((starve_q == STARVE_MAX) & lit_any);
    lit_go   = rst_n & space & lit_any & ~copy_win;
    lit_ready  = lit_go ? grant_oh : '0;
    copy_ready = copy_win;
    push       = copy_win | lit_go;
    if (copy_win) begin
      push_entry = {copy_data, copy_address, copy_byte_valid};
    end else begin
      push_entry = {lit_data[grant_idx*DATA_W +: DATA_W],
                    lit_address[grant_idx*ADDR_W +: ADDR_W],
                    lit_byte_valid[grant_idx*BV_W +: BV_W]};
    end
  end

  // Next-state for round-robin base and copy starvation counter
  always_comb begin
    base_d   = base_q;
    starve_d = starve_q;
    if (lit_go) begin
      base_d = {grant_oh[NUM_PARSER-2:0], grant_oh[NUM_PARSER-1]};
    end
    if (!lit_any || lit_go) begin
      starve_d = '0;
    end else if (copy_win && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Next-state for FIFO pointers, occupancy and storage
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= NUM_PARSER'(1);
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      base_q   <= base_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule
